// File: rtl/uart_tx_scheduler.sv
// uart_tx_scheduler: round-robin sharing of one UART TX engine (tx_start/tx_busy) among NUM_REQ byte producers.
// Define UART_ARB_TAG_EN to send a {TAG_PREFIX, grant_id} tag frame ahead of every data frame.
module uart_tx_scheduler #(
  parameter int         NUM_REQ       = 4,
  parameter int         IDW           = 2,
  parameter int         START_TIMEOUT = 64,
  parameter logic [3:0] TAG_PREFIX    = 4'hA
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [NUM_REQ-1:0]   req_valid,
  input  logic [8*NUM_REQ-1:0] req_data,
  output logic [NUM_REQ-1:0]   req_ready,
  output logic [7:0]           tx_data,
  output logic                 tx_start,
  input  logic                 tx_busy,
  output logic [IDW-1:0]       grant_id,
  output logic                 active,
  output logic                 err_timeout
);

  localparam int CW = $clog2(START_TIMEOUT + 1);
  localparam logic [CW-1:0] TO_LAST = CW'(START_TIMEOUT - 1);
  localparam logic [CW-1:0] TO_MAX  = CW'(START_TIMEOUT);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_GRANT   = 3'd1,
    S_START   = 3'd2,
    S_WAIT_HI = 3'd3,
    S_WAIT_LO = 3'd4
  } state_t;

  state_t             r_state;
  logic [NUM_REQ-1:0] r_req_ready;
  logic [7:0]         r_tx_data;
  logic               r_tx_start;
  logic [IDW-1:0]     r_grant_id;
  logic               r_active;
  logic               r_err;
  logic [CW-1:0]      r_cnt;

  logic [IDW:0]       w_sum;
  logic [IDW-1:0]     w_pick;
  logic               w_any;
  logic [7:0]         w_slice;
  logic [CW-1:0]      w_cnt_inc;

`ifdef UART_ARB_TAG_EN
  logic [7:0]         r_hold;
  logic               r_tag_phase;
`else
  logic               w_unused_tag;
  assign w_unused_tag = ^TAG_PREFIX;
`endif

  // Offsets are walked farthest-first so the nearest valid requester after grant_id wins.
  always_comb begin
    w_pick = r_grant_id;
    w_sum  = '0;
    for (int i = NUM_REQ; i >= 1; i--) begin
      w_sum  = {1'b0, r_grant_id} + (IDW+1)'(i);
      w_sum  = (w_sum >= (IDW+1)'(NUM_REQ)) ? (w_sum - (IDW+1)'(NUM_REQ)) : w_sum;
      w_pick = req_valid[w_sum[IDW-1:0]] ? w_sum[IDW-1:0] : w_pick;
    end
  end

  assign w_any     = |req_valid;
  assign w_slice   = req_data[8*int'(r_grant_id) +: 8];
  assign w_cnt_inc = (r_cnt == TO_MAX) ? r_cnt : (r_cnt + CW'(1));

  // Grant/launch/handshake sequencer; r_cnt holds the cycles elapsed since tx_start.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= S_IDLE;
      r_req_ready <= '0;
      r_tx_data   <= 8'h00;
      r_tx_start  <= 1'b0;
      r_grant_id  <= IDW'(NUM_REQ - 1);
      r_active    <= 1'b0;
      r_err       <= 1'b0;
      r_cnt       <= '0;
`ifdef UART_ARB_TAG_EN
      r_hold      <= 8'h00;
      r_tag_phase <= 1'b0;
`endif
    end else begin
      r_req_ready <= '0;
      r_tx_start  <= 1'b0;
      r_err       <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (w_any && !tx_busy) begin
            r_grant_id  <= w_pick;
            r_req_ready <= NUM_REQ'(1) << w_pick;
            r_active    <= 1'b1;
            r_state     <= S_GRANT;
          end else begin
            r_active    <= 1'b0;
            r_state     <= S_IDLE;
          end
        end
        // A producer that withdraws during its ready pulse loses the byte; nothing is launched.
        S_GRANT: begin
          if (req_valid[r_grant_id]) begin
`ifdef UART_ARB_TAG_EN
            r_hold      <= w_slice;
            r_tx_data   <= {TAG_PREFIX, 4'(r_grant_id)};
            r_tag_phase <= 1'b1;
`else
            r_tx_data   <= w_slice;
`endif
            r_tx_start  <= 1'b1;
            r_state     <= S_START;
          end else begin
            r_active    <= 1'b0;
            r_state     <= S_IDLE;
          end
        end
        S_START: begin
          r_cnt   <= CW'(1);
          r_state <= S_WAIT_HI;
        end
        S_WAIT_HI: begin
          if (tx_busy) begin
            r_state <= S_WAIT_LO;
          end else if (r_cnt >= TO_LAST) begin
            r_cnt    <= w_cnt_inc;
            r_err    <= 1'b1;
            r_active <= 1'b0;
`ifdef UART_ARB_TAG_EN
            r_tag_phase <= 1'b0;
`endif
            r_state  <= S_IDLE;
          end else begin
            r_cnt   <= w_cnt_inc;
            r_state <= S_WAIT_HI;
          end
        end
        S_WAIT_LO: begin
          if (!tx_busy) begin
`ifdef UART_ARB_TAG_EN
            if (r_tag_phase) begin
              r_tag_phase <= 1'b0;
              r_tx_data   <= r_hold;
              r_tx_start  <= 1'b1;
              r_state     <= S_START;
            end else begin
              r_active    <= 1'b0;
              r_state     <= S_IDLE;
            end
`else
            r_active <= 1'b0;
            r_state  <= S_IDLE;
`endif
          end else begin
            r_state <= S_WAIT_LO;
          end
        end
        default: begin
          r_active <= 1'b0;
          r_state  <= S_IDLE;
        end
      endcase
    end
  end

  assign req_ready   = r_req_ready;
  assign tx_data     = r_tx_data;
  assign tx_start    = r_tx_start;
  assign grant_id    = r_grant_id;
  assign active      = r_active;
  assign err_timeout = r_err;

endmodule

// File: tb/tb_uart_tx_scheduler.sv
// Bench for uart_tx_scheduler: random producers and a TX-engine model, compared every cycle
// against a transaction-level reference (event cycle numbers), plus directed literal pins.
`timescale 1ns/1ps
module tb_uart_tx_scheduler;
  localparam int         N    = 4;
  localparam int         IDW  = 2;
  localparam int         T    = 64;
  localparam logic [3:0] TAGP = 4'hA;

  logic           clk = 1'b0;
  logic           rst;
  logic [N-1:0]   req_valid;
  logic [8*N-1:0] req_data;
  logic [N-1:0]   req_ready;
  logic [7:0]     tx_data;
  logic           tx_start;
  logic           tx_busy;
  logic [IDW-1:0] grant_id;
  logic           active;
  logic           err_timeout;

  uart_tx_scheduler #(.NUM_REQ(N), .IDW(IDW), .START_TIMEOUT(T), .TAG_PREFIX(TAGP)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_data(req_data), .req_ready(req_ready),
    .tx_data(tx_data), .tx_start(tx_start), .tx_busy(tx_busy), .grant_id(grant_id),
    .active(active), .err_timeout(err_timeout)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_fail = 0;
  int cyc = 0;

  // reference model: expected event cycles and expected register contents
  bit         m_ok = 1'b0;
  bit         m_xfer = 1'b0;
  bit         m_seen_hi = 1'b0;
  int         m_last = N - 1;
  int         m_ready_c = -10;
  int         m_start_c = -10;
  int         m_err_c = -10;
  int         m_frames = 0;
  logic [7:0] m_txd = 8'h00;
  logic [7:0] m_next = 8'h00;
  logic [7:0] m_hold = 8'h00;

  // stimulus controls
  bit  rand_en = 1'b0, full_en = 1'b0, tx_rand = 1'b0, force_busy = 1'b0;
  int  fix_d = 1, fix_l = 10;
  int  busy_on = 0, busy_off = 0;
  int  rdy_c[N];
  int  q_grants[$];
  logic [7:0] q_frames[$];
  int  n_ready_pulses = 0;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s at cycle %0d: got %0h, expected %0h", name, cyc, got, exp);
    end
  endtask

  task automatic observe();
    int win;
    int d;
    int l;
    int r;
    if (m_ok) begin
      chk("req_ready", 32'(req_ready), (cyc == m_ready_c) ? (32'd1 << m_last) : 32'd0);
      chk("tx_start", 32'(tx_start), 32'(cyc == m_start_c));
      chk("err_timeout", 32'(err_timeout), 32'(cyc == m_err_c));
      chk("active", 32'(active), 32'(m_xfer));
      chk("grant_id", 32'(grant_id), 32'(m_last));
      chk("tx_data", 32'(tx_data), 32'(m_txd));
    end
    for (int i = 0; i < N; i++) begin
      if (req_ready[i] === 1'b1) begin
        rdy_c[i] = cyc;
        q_grants.push_back(i);
        n_ready_pulses++;
      end
    end
    // TX engine reaction to a launch: normal, near-timeout or never-acknowledging
    if (tx_start === 1'b1) begin
      q_frames.push_back(tx_data);
      d = fix_d;
      l = fix_l;
      if (tx_rand) begin
        r = int'($urandom_range(0, 99));
        if (r < 85) begin
          d = int'($urandom_range(1, 4));
          l = int'($urandom_range(1, 12));
        end else if (r < 95) begin
          d = int'($urandom_range(T - 2, T + 1));
          l = int'($urandom_range(1, 4));
        end else begin
          d = 0;
        end
      end
      if (d == 0) begin
        busy_on = 0;
        busy_off = 0;
      end else begin
        busy_on = cyc + d;
        busy_off = cyc + d + l;
      end
    end
    // advance the reference with this cycle's inputs
    if (rst) begin
      m_ok = 1'b1; m_xfer = 1'b0; m_last = N - 1; m_txd = 8'h00;
      m_ready_c = -10; m_start_c = -10; m_err_c = -10;
    end else if (m_ok) begin
      if (!m_xfer) begin
        if (req_valid != '0 && !tx_busy) begin
          win = -1;
          for (int k = 1; k <= N; k++)
            if (win < 0 && req_valid[(m_last + k) % N]) win = (m_last + k) % N;
          m_last = win;
          m_xfer = 1'b1;
          m_seen_hi = 1'b0;
          m_ready_c = cyc + 1;
          m_start_c = cyc + 2;
          m_hold = req_data[8*win +: 8];
`ifdef UART_ARB_TAG_EN
          m_frames = 2;
          m_next = {TAGP, 4'(win)};
`else
          m_frames = 1;
          m_next = m_hold;
`endif
        end
      end else if (cyc > m_start_c) begin
        if (!m_seen_hi) begin
          if (tx_busy) m_seen_hi = 1'b1;
          else if (cyc - m_start_c == T - 1) begin
            m_err_c = cyc + 1;
            m_xfer = 1'b0;
          end
        end else if (!tx_busy) begin
          m_frames--;
          if (m_frames == 0) m_xfer = 1'b0;
          else begin
            m_start_c = cyc + 1;
            m_next = m_hold;
            m_seen_hi = 1'b0;
          end
        end
      end
      if (m_start_c == cyc + 1) m_txd = m_next;
    end
  endtask

  task automatic drive();
    for (int i = 0; i < N; i++) begin
      if (rdy_c[i] == cyc - 1) begin
        if (full_en) req_data[8*i +: 8] = 8'($urandom);
        else req_valid[i] = 1'b0;
      end
      if (rand_en && !req_valid[i] && $urandom_range(0, 3) == 0) begin
        req_valid[i] = 1'b1;
        req_data[8*i +: 8] = 8'($urandom);
      end
    end
    if (rand_en) rst = ($urandom_range(0, 799) == 0);
    tx_busy = force_busy || (cyc >= busy_on && cyc < busy_off);
  endtask

  task automatic tick();
    @(negedge clk);
    observe();
    @(posedge clk);
    cyc++;
    #1;
    drive();
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    rst = 1'b0;
  endtask

  task automatic wait_idle(input string name, input int budget);
    int b = 0;
    while ((active !== 1'b0 || tx_busy) && b < budget) begin
      tick();
      b++;
    end
    chk(name, 32'(active), 32'd0);
  endtask

  task automatic check_reset_pins(input string tag);
    chk({tag, "_grant_id"}, 32'(grant_id), 32'd3);
    chk({tag, "_active"}, 32'(active), 32'd0);
    chk({tag, "_tx_data"}, 32'(tx_data), 32'h00);
    chk({tag, "_req_ready"}, 32'(req_ready), 32'd0);
    chk({tag, "_tx_start"}, 32'(tx_start), 32'd0);
    chk({tag, "_err"}, 32'(err_timeout), 32'd0);
  endtask

  initial begin
    int b;
    int s;
    int exp_g[5] = '{0, 1, 2, 3, 0};
    rst = 1'b1; req_valid = '0; req_data = '0; tx_busy = 1'b0;
    for (int i = 0; i < N; i++) rdy_c[i] = -10;
    @(posedge clk);
    #1;
    tick();
    tick();
    rst = 1'b0;
    check_reset_pins("reset");

`ifndef UART_ARB_TAG_EN
    // single requester, 10-cycle frame starting one cycle after tx_start
    fix_d = 1; fix_l = 10;
    req_valid = 4'b0001; req_data[7:0] = 8'h55;
    tick();
    chk("t1_ready_c1", 32'(req_ready), 32'b0001);
    tick();
    chk("t1_start_c2", 32'(tx_start), 32'd1);
    chk("t1_data_c2", 32'(tx_data), 32'h55);
    repeat (11) tick();
    chk("t1_active_in_frame", 32'(active), 32'd1);
    tick();
    chk("t1_active_after", 32'(active), 32'd0);
`else
    // tag then data frame for requester 2, one ready pulse
    fix_d = 1; fix_l = 3;
    q_frames.delete(); n_ready_pulses = 0;
    req_valid = 4'b0100; req_data[23:16] = 8'h3C;
    b = 0;
    while (!(q_frames.size() >= 2 && active === 1'b0) && b < 100) begin tick(); b++; end
    chk("t6_frames", 32'(q_frames.size()), 32'd2);
    chk("t6_tag", 32'(q_frames[0]), 32'hA2);
    chk("t6_data", 32'(q_frames[1]), 32'h3C);
    chk("t6_ready_once", 32'(n_ready_pulses), 32'd1);
`endif

    // all requesters permanently loaded: strict rotation from requester 0
    do_reset();
    fix_d = 1; fix_l = 2; full_en = 1'b1;
    req_valid = '1; req_data = {8'h44, 8'h33, 8'h22, 8'h11};
    q_grants.delete();
    b = 0;
    while (q_grants.size() < 5 && b < 300) begin tick(); b++; end
    full_en = 1'b0;
    for (int k = 0; k < 5; k++) chk($sformatf("t2_grant%0d", k), 32'(q_grants[k]), 32'(exp_g[k]));
    b = 0;
    while ((req_valid != '0 || active !== 1'b0 || tx_busy) && b < 300) begin tick(); b++; end
    chk("t2_drained", 32'(req_valid), 32'd0);

    // engine never acknowledges: timeout exactly T cycles after tx_start, then recovery
    fix_d = 0;
    req_valid[1] = 1'b1; req_data[15:8] = 8'h77;
    b = 0;
    while (tx_start !== 1'b1 && b < 20) begin tick(); b++; end
    chk("t3_start_seen", 32'(tx_start), 32'd1);
    s = cyc;
    b = 0;
    while (err_timeout !== 1'b1 && b < T + 20) begin tick(); b++; end
    chk("t3_timeout_latency", 32'(cyc - s), 32'(T));
    chk("t3_idle_on_err", 32'(active), 32'd0);
    fix_d = 1; fix_l = 4;
    req_valid[2] = 1'b1; req_data[23:16] = 8'h99;
    b = 0;
    while (req_ready === 4'b0000 && b < 20) begin tick(); b++; end
    chk("t3_next_served", 32'(req_ready), 32'b0100);
    wait_idle("t3_idle", 100);

    // busy held in IDLE blocks the grant until one cycle after it falls
    force_busy = 1'b1; tx_busy = 1'b1;
    req_valid[1] = 1'b1; req_data[15:8] = 8'h5A;
    repeat (6) begin
      tick();
      chk("t4_no_grant", 32'(req_ready), 32'd0);
    end
    force_busy = 1'b0; tx_busy = 1'b0;
    tick();
    chk("t4_grant_after_busy", 32'(req_ready), 32'b0010);
    wait_idle("t4_idle", 100);

    // reset while waiting for the frame to end
    fix_d = 1; fix_l = 10;
    req_valid[3] = 1'b1; req_data[31:24] = 8'hC3;
    b = 0;
    while (!(m_xfer && m_seen_hi) && b < 30) begin tick(); b++; end
    chk("t5_in_wait_lo", 32'(active), 32'd1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check_reset_pins("t5");
    wait_idle("t5_idle", 100);

    // randomized traffic, engine behaviour and occasional resets
    rand_en = 1'b1; tx_rand = 1'b1;
    repeat (4000) tick();
    rand_en = 1'b0; tx_rand = 1'b0; rst = 1'b0; fix_d = 1; fix_l = 3;
    b = 0;
    while ((req_valid != '0 || active !== 1'b0 || tx_busy) && b < 2000) begin tick(); b++; end
    chk("final_drain", 32'(req_valid), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
